// File: rtl/gat_layer_sequencer_pkg.sv
// Shared types and sizing helpers for the GAT layer sequencer.
package gat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    RUN,
    DRAIN,
    DONE,
    ERR
  } seq_state_e;

  function automatic int calc_depth(input int num_subgraphs, input int num_feature_out);
    return num_subgraphs * num_feature_out;
  endfunction

  function automatic int calc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/gat_layer_sequencer_if.sv
// Feature output stream: valid/ready handshake with a last-word marker.
interface gat_layer_sequencer_if #(
  parameter int DATA_W = 32
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/gat_layer_sequencer_fifo.sv
// Small synchronous FIFO that absorbs BRAM read data while the stream is stalled.
module gat_feat_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CNT_W-1:0] o_count
);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count != CNT_FULL);
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/gat_layer_sequencer.sv
// Runs one GAT layer: gates host load flags into a single start, waits for gat_ready,
// then streams the new-feature BRAM out with credit-based read issue.
// state     | meaning
// IDLE      | out of reset, no run yet
// WAIT_LOAD | waiting for all three host load flags high together
// RUN       | gat_top computing; load_done outs high, run_cycles counting
// DRAIN     | reading feature BRAM into the skid FIFO and streaming it out
// DONE      | run complete, done held until next start
// ERR       | RUN timed out, err_timeout held until next start
module gat_layer_sequencer
  import gat_pkg::*;
#(
  parameter int NEW_FEATURE_WIDTH  = 32,
  parameter int NUM_SUBGRAPHS      = 2708,
  parameter int NUM_FEATURE_OUT    = 16,
  parameter int NEW_FEATURE_DEPTH  = calc_depth(NUM_SUBGRAPHS, NUM_FEATURE_OUT),
  parameter int NEW_FEATURE_ADDR_W = calc_addr_w(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LAT        = 2,
  parameter int TIMEOUT_W          = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_start,
  input  logic                          i_cfg_layer,
  input  logic [TIMEOUT_W-1:0]          i_cfg_timeout,
  input  logic                          i_host_h_data_done,
  input  logic                          i_host_h_node_info_done,
  input  logic                          i_host_wgt_done,
  output logic                          o_gat_layer,
  output logic                          o_h_data_bram_load_done,
  output logic                          o_h_node_info_bram_load_done,
  output logic                          o_wgt_bram_load_done,
  input  logic                          i_gat_ready,
  output logic [NEW_FEATURE_ADDR_W+1:0] o_feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  i_feat_bram_dout,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_err_timeout,
  output logic [TIMEOUT_W-1:0]          o_run_cycles,
  gat_layer_sequencer_if.master         m_axis
);
  localparam int FIFO_DEPTH = BRAM_RD_LAT + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int IDX_W      = NEW_FEATURE_ADDR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NEW_FEATURE_DEPTH - 1);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(NEW_FEATURE_DEPTH);
  localparam logic [CNT_W:0]   CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  seq_state_e                   r_state;
  seq_state_e                   w_state_nxt;
  logic                         r_layer;
  logic [TIMEOUT_W-1:0]         r_timeout;
  logic [TIMEOUT_W-1:0]         r_run_cycles;
  logic [IDX_W-1:0]             r_rd_idx;
  logic [IDX_W-1:0]             r_out_idx;
  logic [BRAM_RD_LAT-1:0]       r_vpipe;
  logic                         w_start_ok;
  logic                         w_loads_ready;
  logic                         w_timeout_hit;
  logic                         w_issue;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_tvalid;
  logic                         w_tlast;
  logic [CNT_W-1:0]             w_fifo_count;
  logic [CNT_W:0]               w_occupied;
  logic [NEW_FEATURE_WIDTH-1:0] w_fifo_head;

  assign w_loads_ready = i_host_h_data_done && i_host_h_node_info_done && i_host_wgt_done;
  assign w_timeout_hit = (r_timeout != '0) && (r_run_cycles == r_timeout - 1'b1);

  // Reads are only issued when the FIFO is guaranteed room for everything in flight.
  assign w_occupied = {1'b0, w_fifo_count} + (CNT_W + 1)'($countones(r_vpipe));
  assign w_issue    = (r_state == DRAIN) && (r_rd_idx < DEPTH_IDX) && (w_occupied < CREDIT_LIM);
  assign w_push     = r_vpipe[BRAM_RD_LAT-1];
  assign w_tvalid   = (w_fifo_count != '0);
  assign w_tlast    = w_tvalid && (r_out_idx == LAST_IDX);
  assign w_pop      = w_tvalid && m_axis.tready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (i_start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = WAIT_LOAD;
        end
      end
      WAIT_LOAD: if (w_loads_ready) w_state_nxt = RUN;
      RUN: begin
        if (i_gat_ready)        w_state_nxt = DRAIN;
        else if (w_timeout_hit) w_state_nxt = ERR;
      end
      DRAIN:   if (w_pop && w_tlast) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_layer      <= 1'b0;
      r_timeout    <= '0;
      r_run_cycles <= '0;
      r_rd_idx     <= '0;
      r_out_idx    <= '0;
      r_vpipe      <= '0;
    end else begin
      if (w_start_ok) begin
        r_layer      <= i_cfg_layer;
        r_timeout    <= i_cfg_timeout;
        r_run_cycles <= '0;
        r_rd_idx     <= '0;
        r_out_idx    <= '0;
      end else begin
        if ((r_state == RUN) && (r_run_cycles != '1)) r_run_cycles <= r_run_cycles + 1'b1;
        if (w_issue) r_rd_idx <= r_rd_idx + 1'b1;
        if (w_pop)   r_out_idx <= r_out_idx + 1'b1;
      end
      r_vpipe <= (r_vpipe << 1) | BRAM_RD_LAT'(w_issue);
    end
  end

  gat_feat_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (NEW_FEATURE_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_start_ok),
    .i_push  (w_push),
    .i_wdata (i_feat_bram_dout),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_count (w_fifo_count)
  );

  assign o_gat_layer                  = r_layer;
  assign o_h_data_bram_load_done      = (r_state == RUN);
  assign o_h_node_info_bram_load_done = (r_state == RUN);
  assign o_wgt_bram_load_done         = (r_state == RUN);
  assign o_feat_bram_addrb            = {r_rd_idx[NEW_FEATURE_ADDR_W-1:0], 2'b00};
  assign o_busy                       = (r_state == WAIT_LOAD) || (r_state == RUN) || (r_state == DRAIN);
  assign o_done                       = (r_state == DONE);
  assign o_err_timeout                = (r_state == ERR);
  assign o_run_cycles                 = r_run_cycles;

  assign m_axis.tvalid = w_tvalid;
  assign m_axis.tdata  = w_tvalid ? w_fifo_head : '0;
  assign m_axis.tlast  = w_tlast;
endmodule

// File: tb/tb_gat_layer_sequencer.sv
// Randomized bench for gat_layer_sequencer against a run-level reference model.
module tb_gat_layer_sequencer;
  localparam int W     = 32;
  localparam int NSG   = 4;
  localparam int NFO   = 2;
  localparam int DEPTH = NSG * NFO;
  localparam int AW    = 3;
  localparam int LAT   = 2;
  localparam int TW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cfg_layer;
  logic [TW-1:0] cfg_timeout;
  logic          h_data;
  logic          h_node;
  logic          h_wgt;
  logic          gat_layer;
  logic          ld_h;
  logic          ld_n;
  logic          ld_w;
  logic          gat_ready;
  logic [AW+1:0] addrb;
  logic [W-1:0]  dout;
  logic          busy;
  logic          done;
  logic          err;
  logic [TW-1:0] run_cycles;
  logic [W-1:0]  bram_pipe [LAT];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gat_layer_sequencer_if #(.DATA_W(W)) m_if ();

  gat_layer_sequencer #(
    .NEW_FEATURE_WIDTH (W),
    .NUM_SUBGRAPHS     (NSG),
    .NUM_FEATURE_OUT   (NFO),
    .BRAM_RD_LAT       (LAT),
    .TIMEOUT_W         (TW)
  ) dut (
    .clk                          (clk),
    .rst                          (rst),
    .i_start                      (start),
    .i_cfg_layer                  (cfg_layer),
    .i_cfg_timeout                (cfg_timeout),
    .i_host_h_data_done           (h_data),
    .i_host_h_node_info_done      (h_node),
    .i_host_wgt_done              (h_wgt),
    .o_gat_layer                  (gat_layer),
    .o_h_data_bram_load_done      (ld_h),
    .o_h_node_info_bram_load_done (ld_n),
    .o_wgt_bram_load_done         (ld_w),
    .i_gat_ready                  (gat_ready),
    .o_feat_bram_addrb            (addrb),
    .i_feat_bram_dout             (dout),
    .o_busy                       (busy),
    .o_done                       (done),
    .o_err_timeout                (err),
    .o_run_cycles                 (run_cycles),
    .m_axis                       (m_if)
  );

  // Feature BRAM: word at byte address a holds a/4 + 100, LAT cycles of read latency.
  always @(posedge clk) begin
    bram_pipe[0] <= W'(addrb) / 4 + 100;
    for (int k = 1; k < LAT; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign dout = bram_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 32'(0));
    chk({pfx, "_done"}, 32'(done), 32'(0));
    chk({pfx, "_err"}, 32'(err), 32'(0));
    chk({pfx, "_ld"}, 32'({ld_h, ld_n, ld_w}), 32'(0));
    chk({pfx, "_layer"}, 32'(gat_layer), 32'(0));
    chk({pfx, "_addr"}, 32'(addrb), 32'(0));
    chk({pfx, "_tvalid"}, 32'(m_if.tvalid), 32'(0));
    chk({pfx, "_tlast"}, 32'(m_if.tlast), 32'(0));
    chk({pfx, "_tdata"}, m_if.tdata, 32'(0));
    chk({pfx, "_runcyc"}, run_cycles, 32'(0));
  endtask

  task automatic start_run(input logic layer, input logic [TW-1:0] tmo);
    cfg_layer   = layer;
    cfg_timeout = tmo;
    start       = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'(1));
    chk("start_done", 32'(done), 32'(0));
    chk("start_err", 32'(err), 32'(0));
    chk("start_layer", 32'(gat_layer), 32'(layer));
    chk("start_runcyc", run_cycles, 32'(0));
  endtask

  // Streams the whole layer out; expected words are 100..DEPTH+99 in order.
  task automatic drain(input int pct, input int start_at, input logic exp_layer);
    logic [W-1:0] exp_q[$];
    int           got   = 0;
    int           cyc   = 0;
    int           first = -1;
    int           last  = -1;
    logic         pend  = 1'b0;
    logic [W-1:0] pdata = '0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(W'(100 + i));
    while (got < DEPTH && cyc < 300) begin
      m_if.tready = ($urandom_range(0, 99) < pct);
      start       = (cyc == start_at);
      if (pend) begin
        chk("hold_valid", 32'(m_if.tvalid), 32'(1));
        chk("hold_data", m_if.tdata, pdata);
      end
      if (m_if.tvalid) begin
        if (first < 0) first = cyc;
        chk("tlast", 32'(m_if.tlast), 32'(got == DEPTH - 1));
      end
      if (m_if.tvalid && m_if.tready) begin
        chk("data", m_if.tdata, exp_q.pop_front());
        if (got == DEPTH - 1) begin
          chk("busy_drain", 32'(busy), 32'(1));
          chk("layer_drain", 32'(gat_layer), 32'(exp_layer));
          last = cyc;
        end
        got++;
        pend = 1'b0;
      end else begin
        pend  = m_if.tvalid;
        pdata = m_if.tdata;
      end
      step();
      cyc++;
    end
    start       = 1'b0;
    m_if.tready = 1'b0;
    chk("drain_words", 32'(got), 32'(DEPTH));
    if (pct >= 100) chk("drain_span", 32'(last - first + 1), 32'(DEPTH));
    chk("end_done", 32'(done), 32'(1));
    chk("end_busy", 32'(busy), 32'(0));
    chk("end_err", 32'(err), 32'(0));
    chk("end_tvalid", 32'(m_if.tvalid), 32'(0));
  endtask

  // Full run: staggered host flags, gat_ready after n_run RUN cycles, then drain.
  task automatic do_run(input logic layer, input int n_run, input int pct, input int start_at);
    int t[3];
    int tmax = 0;
    for (int k = 0; k < 3; k++) begin
      t[k] = $urandom_range(0, 5);
      if (t[k] > tmax) tmax = t[k];
    end
    start_run(layer, '0);
    for (int c = 0; c <= tmax; c++) begin
      h_data = (t[0] <= c);
      h_node = (t[1] <= c);
      h_wgt  = (t[2] <= c);
      if (n_run == 1 && c == tmax) gat_ready = 1'b1;
      step();
      if (c < tmax) chk("ld_early", 32'({ld_h, ld_n, ld_w}), 32'(0));
      else          chk("ld_together", 32'({ld_h, ld_n, ld_w}), 32'(7));
    end
    cfg_layer = ~layer;
    for (int k = 1; k < n_run; k++) begin
      if (k == 1) begin
        h_data = 1'b0;
        h_node = 1'b0;
        h_wgt  = 1'b0;
      end
      step();
    end
    if (n_run > 1) chk("ld_hold", 32'({ld_h, ld_n, ld_w}), 32'(7));
    gat_ready = 1'b1;
    step();
    gat_ready = 1'b0;
    h_data    = 1'b0;
    h_node    = 1'b0;
    h_wgt     = 1'b0;
    chk("drain_ld", 32'({ld_h, ld_n, ld_w}), 32'(0));
    chk("run_cycles", run_cycles, 32'(n_run));
    chk("drain_layer", 32'(gat_layer), 32'(layer));
    drain(pct, start_at, layer);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    cfg_layer   = 1'b0;
    cfg_timeout = '0;
    h_data      = 1'b0;
    h_node      = 1'b0;
    h_wgt       = 1'b0;
    gat_ready   = 1'b0;
    m_if.tready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    check_zero("reset");

    // gat_ready after 20 RUN cycles, full-rate stream, cfg_layer flipped mid-run
    do_run(1'b1, 20, 100, -1);

    // gat_ready already high on RUN entry, 50% backpressure, start pulse mid-drain
    do_run(1'b0, 1, 50, 3);

    // timeout of 10 RUN cycles with gat_ready never arriving
    start_run(1'b0, 32'd10);
    h_data = 1'b1;
    h_node = 1'b1;
    h_wgt  = 1'b1;
    step();
    chk("tmo_ld_run", 32'({ld_h, ld_n, ld_w}), 32'(7));
    repeat (9) step();
    chk("tmo_not_yet", 32'(err), 32'(0));
    chk("tmo_busy_run", 32'(busy), 32'(1));
    step();
    chk("tmo_err", 32'(err), 32'(1));
    chk("tmo_busy", 32'(busy), 32'(0));
    chk("tmo_done", 32'(done), 32'(0));
    chk("tmo_ld", 32'({ld_h, ld_n, ld_w}), 32'(0));
    chk("tmo_runcyc", run_cycles, 32'(10));
    h_data = 1'b0;
    h_node = 1'b0;
    h_wgt  = 1'b0;

    // reset while the FIFO holds stalled data, then a clean full run
    start_run(1'b1, '0);
    h_data    = 1'b1;
    h_node    = 1'b1;
    h_wgt     = 1'b1;
    gat_ready = 1'b1;
    step();
    step();
    gat_ready = 1'b0;
    h_data    = 1'b0;
    h_node    = 1'b0;
    h_wgt     = 1'b0;
    repeat (6) step();
    chk("stall_tvalid", 32'(m_if.tvalid), 32'(1));
    chk("stall_head", m_if.tdata, 32'(100));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_zero("midrst");
    do_run(1'b0, 5, 100, -1);

    for (int r = 0; r < 4; r++) begin
      do_run(1'($urandom_range(0, 1)), $urandom_range(1, 30), $urandom_range(30, 100), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
